// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Latency: a byte is visible on m_valid/m_data one cycle after its stop-bit sample; full FIFO drops bytes and flags overrun.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [7:0]               m_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_err,
  output logic                     overrun,
  input  logic                     err_clr
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(BIT_CYC + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    mem [DEPTH];

  logic bit_end, half_end, push_evt, ferr_evt;
  logic empty, full, pop, do_push, drop;

  assign bit_end  = (cnt == BIT_LAST);
  assign half_end = (cnt == HALF_LAST);
  assign push_evt = (state == S_STOP) && bit_end && rx_s;
  assign ferr_evt = (state == S_STOP) && bit_end && !rx_s;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_push = push_evt && (!full || pop);
  assign drop    = push_evt && full && !pop;

  assign m_valid    = !empty;
  assign m_data     = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (half_end) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_BRK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BRK: begin
          // Hold here while the line stays low so a break is not decoded as frames.
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shift_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Clear wins over a same-cycle set; the coinciding event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (err_clr)       frame_err <= 1'b0;
      else if (ferr_evt) frame_err <= 1'b1;
      if (err_clr)       overrun <= 1'b0;
      else if (drop)     overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based receive model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BIT_CYC = 25000000 / 115200;  // 217
  localparam int HALF    = BIT_CYC / 2;        // 108
  localparam int DEPTH   = 8;
  localparam int PERIOD  = 10;
  // Edges from start-bit drive edge to stop-bit sample: 2 sync + 1 detect + HALF + 9 bits.
  localparam int LAT_EDGES = 3 + HALF + 9 * BIT_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [3:0] fifo_level;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.CLK_FREQ(25000000), .BAUD(115200), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_level(fifo_level), .frame_err(frame_err), .overrun(overrun),
    .err_clr(err_clr)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: expected FIFO contents and flags; one pending frame outcome at a known edge time.
  logic [7:0] mq[$];
  bit         mod_fe = 1'b0;
  bit         mod_ov = 1'b0;
  longint     pend_time = -1;
  logic [7:0] pend_byte = 8'h00;
  int         pend_kind = 0;  // 1: good frame, 2: bad stop bit
  bit         mdl_pop, mdl_push, mdl_ferr, mdl_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mod_fe = 1'b0;
      mod_ov = 1'b0;
    end else begin
      mdl_pop  = (mq.size() != 0) && m_ready;
      mdl_push = (pend_kind == 1) && ($time == pend_time);
      mdl_ferr = (pend_kind == 2) && ($time == pend_time);
      mdl_drop = 1'b0;
      if (mdl_pop) void'(mq.pop_front());
      if (mdl_push) begin
        if (mq.size() < DEPTH) mq.push_back(pend_byte);
        else mdl_drop = 1'b1;
      end
      if (err_clr) begin
        mod_fe = 1'b0;
        mod_ov = 1'b0;
      end else begin
        if (mdl_ferr) mod_fe = 1'b1;
        if (mdl_drop) mod_ov = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", 32'(m_valid), 32'(mq.size() != 0));
    chk("cyc_level", 32'(fifo_level), 32'(mq.size()));
    if (mq.size() != 0) chk("cyc_data", 32'(m_data), 32'(mq[0]));
    else if (!rst_n)    chk("rst_data", 32'(m_data), 32'h0);
    chk("cyc_frame_err", 32'(frame_err), 32'(mod_fe));
    chk("cyc_overrun", 32'(overrun), 32'(mod_ov));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    @(posedge clk);
    #1;
    rx        = 1'b0;
    pend_byte = b;
    pend_kind = stop_ok ? 1 : 2;
    pend_time = $time - 1 + longint'(LAT_EDGES) * PERIOD;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(BIT_CYC);
      rx = b[i];
    end
    wait_cyc(BIT_CYC);
    rx = stop_ok;
    if (!stop_ok) begin
      wait_cyc(2 * BIT_CYC);
      rx = 1'b1;
    end
    wait_cyc(2 * BIT_CYC);
  endtask

  task automatic pop_expect(input logic [7:0] b);
    @(negedge clk);
    chk("drain_valid", 32'(m_valid), 32'h1);
    chk("drain_data", 32'(m_data), 32'(b));
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
  endtask

  longint d;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_data0", 32'(m_data), 32'h0);
    chk("rst_flags", {30'h0, frame_err, overrun}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(5);

    // Single byte, held at the head.
    send(8'hA5, 1'b1);
    @(negedge clk);
    chk("a5_valid", 32'(m_valid), 32'h1);
    chk("a5_data", 32'(m_data), 32'hA5);
    chk("a5_level", 32'(fifo_level), 32'h1);
    chk("a5_flags", {30'h0, frame_err, overrun}, 32'h0);

    // 50-cycle low glitch is rejected.
    @(posedge clk);
    #1;
    rx = 1'b0;
    wait_cyc(50);
    rx = 1'b1;
    wait_cyc(2 * BIT_CYC);
    @(negedge clk);
    chk("glitch_level", 32'(fifo_level), 32'h1);
    chk("glitch_flags", {30'h0, frame_err, overrun}, 32'h0);
    pop_expect(8'hA5);

    // Bad stop bit held low, then recovery.
    send(8'h3C, 1'b0);
    @(negedge clk);
    chk("ferr_set", 32'(frame_err), 32'h1);
    chk("ferr_level", 32'(fifo_level), 32'h0);
    pulse_clr();
    @(negedge clk);
    chk("ferr_clr", 32'(frame_err), 32'h0);
    send(8'h5A, 1'b1);
    pop_expect(8'h5A);

    // Overflow: nine bytes into eight slots.
    for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
    @(negedge clk);
    chk("full_level", 32'(fifo_level), 32'h8);
    chk("full_overrun", 32'(overrun), 32'h1);
    for (int i = 0; i < 8; i++) pop_expect(8'(i));
    @(negedge clk);
    chk("drained_valid", 32'(m_valid), 32'h0);

    // Full FIFO with a pop on the push edge accepts the new byte.
    for (int i = 0; i < 8; i++) send(8'(i), 1'b1);
    fork
      send(8'h09, 1'b1);
      begin
        @(posedge clk);
        #2;
        d = pend_time - 9 - $time;
        #(d);
        m_ready = 1'b1;
        #(PERIOD);
        m_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("fullpop_level", 32'(fifo_level), 32'h8);
    chk("fullpop_overrun", 32'(overrun), 32'h1);
    chk("fullpop_head", 32'(m_data), 32'h01);
    for (int i = 1; i < 8; i++) pop_expect(8'(i));
    pop_expect(8'h09);
    pulse_clr();

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    @(posedge clk);
    #1;
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    rx = 1'b1;
    wait_cyc(4 * BIT_CYC + 50);
    rst_n = 1'b0;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(6 * BIT_CYC);
    @(negedge clk);
    chk("rst_mid_level", 32'(fifo_level), 32'h0);
    send(8'h81, 1'b1);
    @(negedge clk);
    chk("r81_level", 32'(fifo_level), 32'h1);
    chk("r81_data", 32'(m_data), 32'h81);
    chk("r81_flags", {30'h0, frame_err, overrun}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
